// File: rtl/cnt_sched_ctrl.sv
// Round-robin scheduler for a shared loadable up-counter: grants timed intervals to two requesters.
// Optional run-time counter checker (sticky err output) enabled by defining CNT_SCHED_CHECK_EN.
module cnt_sched_ctrl #(
   parameter int unsigned WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic [WIDTH-1:0] len0,
   input  logic             req1,
   input  logic [WIDTH-1:0] len1,
   input  logic             hold,
   output logic             gnt0,
   output logic             gnt1,
   output logic             done0,
   output logic             done1,
   output logic             busy,
   output logic [WIDTH-1:0] cnt_in,
   output logic             load,
   output logic             enab,
   input  logic [WIDTH-1:0] cnt_out
`ifdef CNT_SCHED_CHECK_EN
   ,
   output logic             err
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic             owner_q, owner_d;
   logic             last_q, last_d;
   logic [WIDTH-1:0] len_q, len_d;
   logic             gnt0_q, gnt0_d;
   logic             gnt1_q, gnt1_d;
   logic             done0_q, done0_d;
   logic             done1_q, done1_d;
   logic             busy_q, busy_d;
   logic             load_q, load_d;
   logic             pick;
   logic             at_len;

   // The interval ends when the counter reaches the captured length.
   assign at_len = (cnt_out == len_q);

   // Next-state, arbitration and registered-output decode.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      len_d   = len_q;
      pick    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               pick    = (req0 && req1) ? ~last_q : req1;
               owner_d = pick;
               last_d  = pick;
               len_d   = pick ? len1 : len0;
               state_d = LOAD;
            end
         end
         LOAD: state_d = RUN;
         RUN: begin
            if (at_len) begin
               state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      gnt0_d  = (state_d == LOAD) && !owner_d;
      gnt1_d  = (state_d == LOAD) &&  owner_d;
      load_d  = (state_d == LOAD);
      done0_d = (state_d == DONE) && !owner_d;
      done1_d = (state_d == DONE) &&  owner_d;
      busy_d  = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         len_q   <= '0;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         busy_q  <= 1'b0;
         load_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         len_q   <= len_d;
         gnt0_q  <= gnt0_d;
         gnt1_q  <= gnt1_d;
         done0_q <= done0_d;
         done1_q <= done1_d;
         busy_q  <= busy_d;
         load_q  <= load_d;
      end
   end

   assign gnt0   = gnt0_q;
   assign gnt1   = gnt1_q;
   assign done0  = done0_q;
   assign done1  = done1_q;
   assign busy   = busy_q;
   assign load   = load_q;
   assign cnt_in = '0;

   // Enable must react to the live counter value so the last tick stops exactly at len_q.
   assign enab = (state_q == RUN) && !hold && !at_len;

`ifdef CNT_SCHED_CHECK_EN
   logic [WIDTH-1:0] prev_cnt_q, prev_cnt_d;
   logic             prev_enab_q, prev_enab_d;
   logic             first_run_q, first_run_d;
   logic             err_q, err_d;
   logic             step_bad;
   logic             start_bad;

   // Counter must step by one after each enabled cycle and start from zero after a load.
   always_comb begin
      prev_cnt_d  = cnt_out;
      prev_enab_d = enab;
      first_run_d = (state_q == LOAD);
      step_bad    = (state_q == RUN) && prev_enab_q && (cnt_out != prev_cnt_q + WIDTH'(1));
      start_bad   = (state_q == RUN) && first_run_q && (cnt_out != '0);
      err_d       = err_q || step_bad || start_bad;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_cnt_q  <= '0;
         prev_enab_q <= 1'b0;
         first_run_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         prev_cnt_q  <= prev_cnt_d;
         prev_enab_q <= prev_enab_d;
         first_run_q <= first_run_d;
         err_q       <= err_d;
      end
   end

   assign err = err_q;
`endif

endmodule

// File: doc/cnt_sched_ctrl.md
Name: cnt_sched_ctrl

Overview:
- Scheduler/controller for the shared 5-bit loadable up-counter (ports cnt_in, load, enab, cnt_out).
- Two requesters each ask for a timed interval of N counter ticks.
- The block arbitrates round-robin, loads the counter, gates enable until the interval expires, and signals completion to the winning requester.
- Sits between requester logic and the counter instance. The counter itself is external.

Parameters:
- WIDTH, 5, counter/length width; must match the counter instance.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- req0  input  1  requester 0 interval request (level)
- len0  input  WIDTH  requester 0 interval length in ticks
- req1  input  1  requester 1 interval request (level)
- len1  input  WIDTH  requester 1 interval length in ticks
- hold  input  1  pause; freezes a running interval
- gnt0  output  1  one-cycle grant pulse to requester 0
- gnt1  output  1  one-cycle grant pulse to requester 1
- done0  output  1  one-cycle completion pulse to requester 0
- done1  output  1  one-cycle completion pulse to requester 1
- busy  output  1  high in any state other than IDLE
- cnt_in  output  WIDTH  counter load value; always 0
- load  output  1  counter load strobe
- enab  output  1  counter count enable
- cnt_out  input  WIDTH  counter current value

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, last=1, owner=0, len_q=0.
  - All outputs 0: gnt*, done*, busy, load, enab, cnt_in.
  - Reset asserted mid-interval aborts the interval with no done pulse. The counter is not reloaded by this block until the next grant.
- Counter contract: load has priority over enab. On a load edge, cnt_out becomes cnt_in on the next cycle. On an enab edge, cnt_out increments by 1 mod 2^WIDTH.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - If neither req is high, stay.
  - If exactly one req is high, grant it.
  - If both are high, grant the requester != last.
  - On a grant: go to LOAD next edge, register owner, capture len_q from lenX, set last=owner.
- LOAD (exactly 1 cycle):
  - gnt<owner>=1, load=1, enab=0, cnt_in=0. Go to RUN.
- RUN:
  - enab = !hold && (cnt_out != len_q). This term is combinational from registered state, len_q and cnt_out.
  - When cnt_out == len_q, go to DONE; enab=0 that cycle.
  - len_q=0 produces one RUN cycle, then DONE.
  - len_q=L produces exactly L enabled ticks; hold cycles extend RUN 1:1.
- DONE (exactly 1 cycle):
  - done<owner>=1. Go to IDLE.
  - A new request is arbitrated no earlier than the following IDLE cycle.
- busy=1 in LOAD, RUN and DONE.
- Latency: request seen in IDLE → gnt on the next cycle → first tick one cycle later → done L+2 cycles after gnt, plus hold cycles.
- Request inputs:
  - req/len changes after grant are ignored; len_q is fixed for the interval.
  - req held high through DONE re-requests, and is arbitrated fairly against the other requester.
  - Simultaneous req0/req1 alternate strictly.
- Wrap: len_q=2^WIDTH-1 (31) is legal. The counter never wraps under this block's control.
- gnt0/gnt1 are mutually exclusive, as are done0/done1.

Optional Feature:
- Macro: CNT_SCHED_CHECK_EN.
- When defined, add output err (1 bit, reset 0, sticky until reset). err sets when either check fails:
  - In RUN, a cycle after enab=1 where cnt_out != previous cnt_out + 1.
  - The first RUN cycle after LOAD with cnt_out != 0.
- When undefined: no err port and no checker logic.

Test Plan:
- Reset then req0=1, len0=5, req1=0 → gnt0 on cycle 1; load=1 same cycle; enab high for exactly 5 cycles; done0 one cycle after cnt_out reaches 5; busy low afterward.
- req0=req1=1 held, len0=2, len1=3 → grants alternate gnt0, gnt1, gnt0 …; each done matches its owner.
- req1=1, len1=4, hold=1 for 3 cycles mid-RUN → enab low during hold; done1 delayed exactly 3 cycles; 4 total ticks.
- len0=0 → gnt0, LOAD, one RUN cycle with enab=0, done0; total 3 busy cycles.
- len0=31 → 31 enabled ticks, cnt_out ends at 31, no wrap; rst dropped mid-RUN in a second run → all outputs 0 immediately, no done pulse.
- With CNT_SCHED_CHECK_EN: force cnt_out stuck during RUN → err=1 and stays 1 until rst=0.
